// File: rtl/flash_pll_pkg.sv
// Shared types and helpers for the flash-clock PLL supervisor.
// State encoding, bus widths and counter sizing.
package flash_pll_pkg;

  localparam int PSDA_W   = 4;
  localparam int RELOCK_W = 8;

  typedef enum logic [2:0] {
    RESET_PLL    = 3'd0,
    WAIT_LOCK    = 3'd1,
    STABLE       = 3'd2,
    READY        = 3'd3,
    PHASE_SETTLE = 3'd4,
    FAIL         = 3'd5
  } state_t;

  // Keeps a count of 1 from collapsing to a zero-width vector.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [RELOCK_W-1:0] sat_inc(
    input logic [RELOCK_W-1:0] v
  );
    return (v == '1) ? v : v + RELOCK_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals crossing into clk.
// Resets to zero.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/flash_pll_ctrl.sv
// Flash-clock rPLL supervisor: reset, lock qualification,
// bounded retries and clkoutp phase sequencing.
module flash_pll_ctrl
  import flash_pll_pkg::*;
#(
  parameter int RESET_CYCLES       = 16,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SETTLE_CYCLES      = 8,
  parameter int MAX_RETRIES        = 3,
  parameter logic [PSDA_W-1:0] PSDA_INIT = 4'hF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic [PSDA_W-1:0]   psda,
  output logic                ready,
  output logic                pll_fail,
  input  logic                step_req,
  input  logic                step_dir,
  input  logic                phase_load,
  input  logic [PSDA_W-1:0]   phase_val,
  output logic                step_ack,
  output logic                phase_busy,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam int RW = cnt_w(RESET_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int EW = cnt_w(SETTLE_CYCLES);
  localparam int NW = cnt_w(MAX_RETRIES + 1);

  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] ST_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [EW-1:0] SE_LAST  = EW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] RET_MAX  = NW'(MAX_RETRIES);

  state_t        state;
  logic          lock_s;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] stab_cnt;
  logic [EW-1:0] set_cnt;
  logic [NW-1:0] retries;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RESET_PLL;
      pll_reset    <= 1'b1;
      psda         <= PSDA_INIT;
      ready        <= 1'b0;
      pll_fail     <= 1'b0;
      step_ack     <= 1'b0;
      phase_busy   <= 1'b0;
      relock_count <= '0;
      retries      <= '0;
      rst_cnt      <= '0;
      to_cnt       <= '0;
      stab_cnt     <= '0;
      set_cnt      <= '0;
    end else begin
      step_ack <= 1'b0;
      unique case (state)
        RESET_PLL: begin
          pll_reset <= 1'b1;
          if (rst_cnt == RST_LAST) begin
            state     <= WAIT_LOCK;
            pll_reset <= 1'b0;
            to_cnt    <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state    <= STABLE;
            stab_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            retries   <= retries + NW'(1);
            pll_reset <= 1'b1;
            rst_cnt   <= '0;
            if (retries + NW'(1) == RET_MAX) begin
              state    <= FAIL;
              pll_fail <= 1'b1;
            end else begin
              state <= RESET_PLL;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state  <= WAIT_LOCK;
            to_cnt <= '0;
          end else if (stab_cnt == ST_LAST) begin
            state   <= READY;
            ready   <= 1'b1;
            retries <= '0;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
        READY: begin
          if (!lock_s) begin
            ready        <= 1'b0;
            relock_count <= sat_inc(relock_count);
            state        <= RESET_PLL;
            pll_reset    <= 1'b1;
            rst_cnt      <= '0;
          // The cycle right after an ack still sees the old request.
          end else if (step_req && !step_ack) begin
            if (phase_load)
              psda <= phase_val;
            else if (step_dir)
              psda <= psda + PSDA_W'(1);
            else
              psda <= psda - PSDA_W'(1);
            phase_busy <= 1'b1;
            set_cnt    <= '0;
            state      <= PHASE_SETTLE;
          end
        end
        PHASE_SETTLE: begin
          if (!lock_s) begin
            phase_busy   <= 1'b0;
            ready        <= 1'b0;
            relock_count <= sat_inc(relock_count);
            state        <= RESET_PLL;
            pll_reset    <= 1'b1;
            rst_cnt      <= '0;
          end else if (set_cnt == SE_LAST) begin
            step_ack   <= 1'b1;
            phase_busy <= 1'b0;
            state      <= READY;
          end else begin
            set_cnt <= set_cnt + EW'(1);
          end
        end
        FAIL: begin
          pll_reset <= 1'b1;
          ready     <= 1'b0;
          pll_fail  <= 1'b1;
        end
        default: state <= RESET_PLL;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_pll_ctrl.sv
// Directed bench for flash_pll_ctrl with shortened timing
// parameters and hand-computed expected cycle counts.
module tb_flash_pll_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       step_req = 1'b0;
  logic       step_dir = 1'b0;
  logic       phase_load = 1'b0;
  logic [3:0] phase_val = 4'h0;
  logic       pll_reset;
  logic [3:0] psda;
  logic       ready;
  logic       pll_fail;
  logic       step_ack;
  logic       phase_busy;
  logic [7:0] relock_count;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  flash_pll_ctrl #(
    .RESET_CYCLES       (4),
    .LOCK_TIMEOUT       (32),
    .LOCK_STABLE_CYCLES (8),
    .SETTLE_CYCLES      (4),
    .MAX_RETRIES        (2),
    .PSDA_INIT          (4'hF)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .psda         (psda),
    .ready        (ready),
    .pll_fail     (pll_fail),
    .step_req     (step_req),
    .step_dir     (step_dir),
    .phase_load   (phase_load),
    .phase_val    (phase_val),
    .step_ack     (step_ack),
    .phase_busy   (phase_busy),
    .relock_count (relock_count)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset_n    = 1'b0;
    pll_lock   = 1'b0;
    step_req   = 1'b0;
    phase_load = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_while_reset(input logic lvl, output int n);
    n = 0;
    while (pll_reset === lvl && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (step_ack !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick();
    vecs++; if (pll_reset !== 1'b1) begin miss++; $display("FAIL rst_pll_reset got %b want 1", pll_reset); end
    vecs++; if (psda !== 4'hF) begin miss++; $display("FAIL rst_psda got %h want f", psda); end
    vecs++; if (ready !== 1'b0) begin miss++; $display("FAIL rst_ready got %b want 0", ready); end
    vecs++; if (pll_fail !== 1'b0) begin miss++; $display("FAIL rst_pll_fail got %b want 0", pll_fail); end
    vecs++; if (step_ack !== 1'b0) begin miss++; $display("FAIL rst_step_ack got %b want 0", step_ack); end
    vecs++; if (phase_busy !== 1'b0) begin miss++; $display("FAIL rst_busy got %b want 0", phase_busy); end
    vecs++; if (relock_count !== 8'd0) begin miss++; $display("FAIL rst_relock got %0d want 0", relock_count); end
  endtask

  task automatic test_power_up;
    int n;
    do_reset();
    run_while_reset(1'b1, n);
    vecs++; if (n != 4) begin miss++; $display("FAIL pwr_reset_len got %0d want 4", n); end
    repeat (10) tick();
    vecs++; if (ready !== 1'b0) begin miss++; $display("FAIL pwr_early_ready got %b want 0", ready); end
    pll_lock = 1'b1;
    wait_ready(n);
    vecs++; if (n != 11) begin miss++; $display("FAIL pwr_ready_edges got %0d want 11", n); end
    vecs++; if (pll_fail !== 1'b0) begin miss++; $display("FAIL pwr_pll_fail got %b want 0", pll_fail); end
    vecs++; if (pll_reset !== 1'b0) begin miss++; $display("FAIL pwr_pll_reset got %b want 0", pll_reset); end
  endtask

  task automatic test_glitch;
    int n;
    do_reset();
    run_while_reset(1'b1, n);
    pll_lock = 1'b1;
    repeat (8) tick();
    pll_lock = 1'b0;
    tick();
    vecs++; if (ready !== 1'b0) begin miss++; $display("FAIL glitch_ready got %b want 0", ready); end
    pll_lock = 1'b1;
    wait_ready(n);
    vecs++; if (n != 11) begin miss++; $display("FAIL glitch_ready_edges got %0d want 11", n); end
    vecs++; if (pll_reset !== 1'b0) begin miss++; $display("FAIL glitch_pll_reset got %b want 0", pll_reset); end
  endtask

  task automatic test_timeout;
    int n;
    do_reset();
    run_while_reset(1'b1, n);
    vecs++; if (n != 4) begin miss++; $display("FAIL to_pulse1 got %0d want 4", n); end
    run_while_reset(1'b0, n);
    vecs++; if (n != 32) begin miss++; $display("FAIL to_wait1 got %0d want 32", n); end
    run_while_reset(1'b1, n);
    vecs++; if (n != 4) begin miss++; $display("FAIL to_pulse2 got %0d want 4", n); end
    run_while_reset(1'b0, n);
    vecs++; if (n != 32) begin miss++; $display("FAIL to_wait2 got %0d want 32", n); end
    vecs++; if (pll_fail !== 1'b1) begin miss++; $display("FAIL to_fail got %b want 1", pll_fail); end
    pll_lock = 1'b1;
    repeat (40) tick();
    vecs++; if (pll_fail !== 1'b1) begin miss++; $display("FAIL to_fail_sticky got %b want 1", pll_fail); end
    vecs++; if (pll_reset !== 1'b1) begin miss++; $display("FAIL to_fail_reset got %b want 1", pll_reset); end
    vecs++; if (ready !== 1'b0) begin miss++; $display("FAIL to_fail_ready got %b want 0", ready); end
    reset_n = 1'b0;
    #1;
    vecs++; if (pll_fail !== 1'b0) begin miss++; $display("FAIL to_clear_fail got %b want 0", pll_fail); end
    vecs++; if (psda !== 4'hF) begin miss++; $display("FAIL to_clear_psda got %h want f", psda); end
    tick();
  endtask

  task automatic test_step_wrap;
    int n;
    do_reset();
    run_while_reset(1'b1, n);
    pll_lock = 1'b1;
    wait_ready(n);
    vecs++; if (ready !== 1'b1) begin miss++; $display("FAIL wrap_ready got %b want 1", ready); end
    step_dir = 1'b1;
    step_req = 1'b1;
    tick();
    vecs++; if (psda !== 4'h0) begin miss++; $display("FAIL wrap_up_psda got %h want 0", psda); end
    vecs++; if (phase_busy !== 1'b1) begin miss++; $display("FAIL wrap_busy got %b want 1", phase_busy); end
    vecs++; if (step_ack !== 1'b0) begin miss++; $display("FAIL wrap_early_ack got %b want 0", step_ack); end
    wait_ack(n);
    vecs++; if (n != 4) begin miss++; $display("FAIL wrap_ack_delay got %0d want 4", n); end
    vecs++; if (phase_busy !== 1'b0) begin miss++; $display("FAIL wrap_busy_clr got %b want 0", phase_busy); end
    step_req = 1'b0;
    tick();
    vecs++; if (step_ack !== 1'b0) begin miss++; $display("FAIL wrap_ack_pulse got %b want 0", step_ack); end
    step_dir = 1'b0;
    step_req = 1'b1;
    tick();
    vecs++; if (psda !== 4'hF) begin miss++; $display("FAIL wrap_dn_psda got %h want f", psda); end
    wait_ack(n);
    vecs++; if (n != 4) begin miss++; $display("FAIL wrap_dn_ack got %0d want 4", n); end
    step_req = 1'b0;
    tick();
  endtask

  task automatic test_load;
    int n;
    phase_load = 1'b1;
    phase_val  = 4'h5;
    step_dir   = 1'b1;
    step_req   = 1'b1;
    tick();
    vecs++; if (psda !== 4'h5) begin miss++; $display("FAIL load_psda got %h want 5", psda); end
    wait_ack(n);
    vecs++; if (n != 4) begin miss++; $display("FAIL load_ack got %0d want 4", n); end
    step_req   = 1'b0;
    phase_load = 1'b0;
    tick();
  endtask

  task automatic test_settle_loss;
    int  n;
    logic seen;
    seen     = 1'b0;
    step_dir = 1'b1;
    step_req = 1'b1;
    tick();
    vecs++; if (psda !== 4'h6) begin miss++; $display("FAIL loss_psda_new got %h want 6", psda); end
    tick();
    pll_lock = 1'b0;
    repeat (3) begin
      tick();
      if (step_ack === 1'b1) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0) begin miss++; $display("FAIL loss_no_ack got %b want 0", seen); end
    vecs++; if (ready !== 1'b0) begin miss++; $display("FAIL loss_ready got %b want 0", ready); end
    vecs++; if (relock_count !== 8'd1) begin miss++; $display("FAIL loss_relock got %0d want 1", relock_count); end
    vecs++; if (pll_reset !== 1'b1) begin miss++; $display("FAIL loss_pll_reset got %b want 1", pll_reset); end
    vecs++; if (psda !== 4'h6) begin miss++; $display("FAIL loss_psda_keep got %h want 6", psda); end
    vecs++; if (phase_busy !== 1'b0) begin miss++; $display("FAIL loss_busy got %b want 0", phase_busy); end
    pll_lock = 1'b1;
    wait_ack(n);
    vecs++; if (step_ack !== 1'b1) begin miss++; $display("FAIL loss_pending_ack got %b want 1", step_ack); end
    vecs++; if (psda !== 4'h7) begin miss++; $display("FAIL loss_pending_psda got %h want 7", psda); end
    vecs++; if (ready !== 1'b1) begin miss++; $display("FAIL loss_reready got %b want 1", ready); end
    step_req = 1'b0;
    tick();
  endtask

  task automatic test_relock;
    int n;
    pll_lock = 1'b0;
    n = 0;
    while (ready === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    vecs++; if (n != 3) begin miss++; $display("FAIL relock_drop got %0d want 3", n); end
    vecs++; if (relock_count !== 8'd2) begin miss++; $display("FAIL relock_count got %0d want 2", relock_count); end
    vecs++; if (psda !== 4'h7) begin miss++; $display("FAIL relock_psda got %h want 7", psda); end
  endtask

  task automatic test_reset_mid;
    pll_lock = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    vecs++; if (psda !== 4'hF) begin miss++; $display("FAIL mid_psda got %h want f", psda); end
    vecs++; if (relock_count !== 8'd0) begin miss++; $display("FAIL mid_relock got %0d want 0", relock_count); end
    vecs++; if (pll_reset !== 1'b1) begin miss++; $display("FAIL mid_pll_reset got %b want 1", pll_reset); end
    vecs++; if (ready !== 1'b0) begin miss++; $display("FAIL mid_ready got %b want 0", ready); end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_timeout();
    test_step_wrap();
    test_load();
    test_settle_loss();
    test_relock();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
